// File: rtl/switch_debounce_events.sv
// switch_debounce_events: conditions raw switches into debounced levels and
// one-cycle rise/fall/long-press events, all in the clk_50M domain.
//
// Ports:
//   clk_50M  - system clock
//   rst      - synchronous reset, active-high
//   switch   - raw asynchronous switch inputs, 1 = pressed
//   sw_level - debounced level per channel
//   sw_rise  - one-cycle pulse, level went 0->1
//   sw_fall  - one-cycle pulse, level went 1->0
//   sw_long  - one-cycle pulse, held high LONG_TICKS ticks
//   tick     - one-cycle sample strobe
module switch_debounce_events #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_long,
  output logic             tick
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_w;

  assign tick_w = (div_q == DIV_LAST);
  assign tick   = tick_w;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick_w) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
    end else begin
      sync1_q <= switch;
      sync2_q <= sync1_q;
      div_q   <= div_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [HOLD_W-1:0]   hold_nx;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                long_q, long_d;
    logic                s;

    assign s       = sync2_q[g];
    assign hold_nx = hold_q + HOLD_W'(1);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      level_d = level_q;
      // pulses last one cycle: cleared unless re-set below
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      long_d  = 1'b0;
      if (tick_w) begin
        unique case (state_q)
          S_LOW: begin
            if (s) begin
              state_d = S_RISE_CHK;
              cnt_d   = CNT_W'(1);
            end
          end
          S_RISE_CHK: begin
            if (!s) begin
              state_d = S_LOW;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = S_HIGH;
              level_d = 1'b1;
              rise_d  = 1'b1;
              cnt_d   = '0;
              hold_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_HIGH: begin
            if (!s) begin
              state_d = S_FALL_CHK;
              cnt_d   = CNT_W'(1);
            end else if (hold_q < HOLD_MAX) begin
              // saturates at HOLD_MAX so one press gives one sw_long
              hold_d = hold_nx;
              long_d = (hold_nx == HOLD_MAX);
            end
          end
          S_FALL_CHK: begin
            if (s) begin
              state_d = S_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = S_LOW;
              level_d = 1'b0;
              fall_d  = 1'b1;
              cnt_d   = '0;
              hold_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = S_LOW;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_50M) begin
      if (rst) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        long_q  <= long_d;
      end
    end

    assign sw_level[g] = level_q;
    assign sw_rise[g]  = rise_q;
    assign sw_fall[g]  = fall_q;
    assign sw_long[g]  = long_q;
  end

endmodule

// File: tb/tb_switch_debounce_events.sv
// tb_switch_debounce_events: tick-segment vector table with a scoreboard,
// plus hand sequences for reset, simultaneous events and reset mid-check.
module tb_switch_debounce_events;

  typedef struct {
    logic [1:0] sw;
    int         ticks;
    logic [1:0] lvl;
    logic [5:0] ev;
  } vec_t;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] switch = 2'b00;
  logic [1:0] sw_level;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;
  logic [1:0] sw_long;
  logic       tick;

  int n_checks = 0;
  int n_errors = 0;
  int ev_cnt[6];
  logic       t_last = 1'b0;
  logic [1:0] lvl_last = 2'b00;

  vec_t tbl[$];
  vec_t sb_q[$];

  switch_debounce_events #(
    .WIDTH(2),
    .CLK_DIV(4),
    .DEBOUNCE_TICKS(3),
    .LONG_TICKS(8)
  ) dut (
    .clk_50M(clk_50M),
    .rst(rst),
    .switch(switch),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_long(sw_long),
    .tick(tick)
  );

  always #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) begin
    #2;
    if (!rst) begin
      if ((sw_rise | sw_fall | sw_long) != 2'b00) begin
        n_checks++;
        if (!t_last) begin
          n_errors++;
          $display("FAIL pulse_timing: pulse r=%b f=%b l=%b not after tick",
                   sw_rise, sw_fall, sw_long);
        end
        for (int c = 0; c < 2; c++) begin
          ev_cnt[c]   += int'(sw_rise[c]);
          ev_cnt[2+c] += int'(sw_fall[c]);
          ev_cnt[4+c] += int'(sw_long[c]);
        end
      end
      if (sw_level != lvl_last || sw_rise != 2'b00 || sw_fall != 2'b00) begin
        n_checks++;
        if (sw_rise != (sw_level & ~lvl_last) ||
            sw_fall != (~sw_level & lvl_last)) begin
          n_errors++;
          $display("FAIL level_edge: lvl %b->%b got r=%b f=%b",
                   lvl_last, sw_level, sw_rise, sw_fall);
        end
      end
    end
    lvl_last = sw_level;
    t_last   = tick;
  end

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_tick_edge();
    int g = 0;
    do begin
      @(negedge clk_50M);
      g++;
    end while (!tick && g < 16);
    if (!tick) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected <=4", g);
    end
    @(posedge clk_50M);
    #1;
  endtask

  task automatic run_seg(vec_t v);
    vec_t e;
    logic bad;
    sb_q.push_back(v);
    switch = v.sw;
    for (int k = 0; k < 6; k++) ev_cnt[k] = 0;
    for (int t = 0; t < v.ticks; t++) wait_tick_edge();
    @(negedge clk_50M);
    e = sb_q.pop_front();
    chk($sformatf("seg_level sw=%b", e.sw), {6'd0, sw_level}, {6'd0, e.lvl});
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ev_cnt[k] != int'(e.ev[k])) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL seg_events sw=%b: got r%0d%0d f%0d%0d l%0d%0d expected %b",
               e.sw, ev_cnt[1], ev_cnt[0], ev_cnt[3], ev_cnt[2],
               ev_cnt[5], ev_cnt[4], e.ev);
    end
  endtask

  initial begin
    int k;
    // ev bits: {l1,l0,f1,f0,r1,r0}
    tbl.push_back('{2'b01, 2, 2'b00, 6'b000000});
    tbl.push_back('{2'b01, 1, 2'b01, 6'b000001});
    tbl.push_back('{2'b01, 4, 2'b01, 6'b000000});
    tbl.push_back('{2'b00, 2, 2'b01, 6'b000000});
    tbl.push_back('{2'b00, 1, 2'b00, 6'b000100});
    tbl.push_back('{2'b01, 2, 2'b00, 6'b000000});
    tbl.push_back('{2'b00, 1, 2'b00, 6'b000000});
    tbl.push_back('{2'b01, 2, 2'b00, 6'b000000});
    tbl.push_back('{2'b01, 1, 2'b01, 6'b000001});
    tbl.push_back('{2'b00, 2, 2'b01, 6'b000000});
    tbl.push_back('{2'b01, 1, 2'b01, 6'b000000});
    tbl.push_back('{2'b00, 3, 2'b00, 6'b000100});
    tbl.push_back('{2'b10, 3, 2'b10, 6'b000010});
    tbl.push_back('{2'b10, 7, 2'b10, 6'b000000});
    tbl.push_back('{2'b10, 1, 2'b10, 6'b100000});
    tbl.push_back('{2'b10, 5, 2'b10, 6'b000000});
    tbl.push_back('{2'b00, 2, 2'b10, 6'b000000});
    tbl.push_back('{2'b00, 1, 2'b00, 6'b001000});
    tbl.push_back('{2'b10, 3, 2'b10, 6'b000010});
    tbl.push_back('{2'b10, 5, 2'b10, 6'b000000});
    tbl.push_back('{2'b00, 1, 2'b10, 6'b000000});
    tbl.push_back('{2'b10, 1, 2'b10, 6'b000000});
    tbl.push_back('{2'b10, 2, 2'b10, 6'b000000});
    tbl.push_back('{2'b10, 1, 2'b10, 6'b100000});
    tbl.push_back('{2'b00, 3, 2'b00, 6'b001000});
    tbl.push_back('{2'b10, 3, 2'b10, 6'b000010});
    tbl.push_back('{2'b11, 3, 2'b11, 6'b000001});
    tbl.push_back('{2'b01, 3, 2'b01, 6'b001000});
    tbl.push_back('{2'b00, 3, 2'b00, 6'b000100});

    rst = 1'b1;
    switch = 2'b00;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    chk("reset_outputs", {sw_level, sw_rise, sw_fall, sw_long},
        8'h00);
    chk("reset_tick", {7'd0, tick}, 8'h00);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk_50M);
      k++;
    end while (!tick && k < 16);
    chk("first_tick_delay", 8'(k), 8'd3);
    @(posedge clk_50M);
    @(negedge clk_50M);

    foreach (tbl[i]) run_seg(tbl[i]);

    run_seg('{2'b11, 2, 2'b00, 6'b000000});
    wait_tick_edge();
    chk("simul_rise", {4'd0, sw_rise, sw_level}, 8'h0f);
    @(posedge clk_50M);
    #1;
    chk("simul_rise_clear", {6'd0, sw_rise}, 8'h00);
    @(negedge clk_50M);
    run_seg('{2'b00, 2, 2'b11, 6'b000000});
    wait_tick_edge();
    chk("simul_fall", {4'd0, sw_fall, sw_level}, 8'h0c);
    @(posedge clk_50M);
    #1;
    chk("simul_fall_clear", {6'd0, sw_fall}, 8'h00);
    @(negedge clk_50M);

    run_seg('{2'b01, 2, 2'b00, 6'b000000});
    rst = 1'b1;
    repeat (2) @(negedge clk_50M);
    chk("midreset_outputs", {sw_level, sw_rise, sw_fall, sw_long}, 8'h00);
    rst = 1'b0;
    run_seg('{2'b01, 2, 2'b00, 6'b000000});
    run_seg('{2'b01, 1, 2'b01, 6'b000001});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
